// File: rtl/int_burst_sched_pkg.sv
// rtl/int_burst_sched_pkg.sv - shared types and config clamp for the interrupter scheduler
package int_burst_sched_pkg;

    localparam int US_W = 16;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} sched_state_t;

    typedef struct packed {
        logic [US_W-1:0] period;
        logic [7:0]      pw;
        logic [7:0]      bon;
        logic [7:0]      boff;
    } cfg_t;

    // Pulse width may never reach the period, so OFF always gets at least one us.
    function automatic cfg_t clamp_cfg(input cfg_t c);
        cfg_t r;
        r = c;
        if (c.period != '0 && {8'd0, c.pw} >= c.period) begin
            r.pw = 8'(c.period - 16'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/int_burst_sched_if.sv
// rtl/int_burst_sched_if.sv - host config handshake bus for the interrupter scheduler
interface int_burst_sched_if;
    import int_burst_sched_pkg::*;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [US_W-1:0] cfg_period;
    logic [7:0]      cfg_pw;
    logic [7:0]      cfg_bon;
    logic [7:0]      cfg_boff;

    modport master (
        output cfg_valid, cfg_period, cfg_pw, cfg_bon, cfg_boff,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_pw, cfg_bon, cfg_boff,
        output cfg_ready
    );

endinterface

// File: rtl/int_burst_sched_us_tick_gen.sv
// rtl/int_burst_sched_us_tick_gen.sv - free-running prescaler giving a one-cycle tick per microsecond
module us_tick_gen #(
    parameter int CLK_MHZ = 100
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int            CW   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_MHZ - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/int_burst_sched.sv
// rtl/int_burst_sched.sv - DRSSTC interrupter: period/pulse/burst sequencer with leaky-bucket duty limiter
module int_burst_sched
    import int_burst_sched_pkg::*;
#(
    parameter int CLK_MHZ    = 100,
    parameter int BUCKET_MAX = 4000,
    parameter int K_ON       = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    int_burst_sched_if.slave    cfg_bus,
    output logic                o_pulse_out,
    output logic                o_busy,
    output logic                o_fault_duty,
    output logic [15:0]         o_pulse_cnt
);

    localparam logic [15:0] BKT_HI = 16'(BUCKET_MAX);
    localparam logic [15:0] BKT_LO = 16'(BUCKET_MAX / 2);

    sched_state_t    r_state, w_state_nxt;
    cfg_t            r_active, r_shadow;
    logic            r_pend;
    logic [US_W-1:0] r_us;
    logic [7:0]      r_gap;
    logic [7:0]      r_burst;
    logic            r_pulse;
    logic            r_fault;
    logic [15:0]     r_bucket;
    logic [15:0]     r_pcnt;

    logic            w_tick;
    logic            w_hs;
    cfg_t            w_cfg_in, w_apply_cfg, w_use;
    logic [US_W-1:0] w_us_inc, w_us_d;
    logic [7:0]      w_gap_d, w_burst_d;
    logic            w_apply, w_start, w_restart;
    logic [16:0]     w_bucket_sum;
    logic [15:0]     w_bucket_d;
    logic            w_fault_d, w_pulse_d;

    us_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_hs        = cfg_bus.cfg_valid && !r_pend;
    assign w_cfg_in    = {cfg_bus.cfg_period, cfg_bus.cfg_pw, cfg_bus.cfg_bon, cfg_bus.cfg_boff};
    assign w_apply_cfg = clamp_cfg(r_shadow);
    // Config that governs a period starting this cycle: a pending shadow takes over here.
    assign w_use       = r_pend ? w_apply_cfg : r_active;
    assign w_us_inc    = r_us + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_us_d      = r_us;
        w_gap_d     = r_gap;
        w_burst_d   = r_burst;
        w_apply     = 1'b0;
        w_start     = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            IDLE: if (w_tick) begin
                w_apply = r_pend;
                w_start = i_en && (w_use.period != '0);
            end
            ON: if (w_tick) begin
                w_us_d = w_us_inc;
                if (w_us_inc == {8'd0, r_active.pw}) w_state_nxt = OFF;
            end
            OFF: if (w_tick) begin
                w_us_d = w_us_inc;
                if (w_us_inc == r_active.period) begin
                    if (r_active.boff != '0 && r_burst >= r_active.bon) begin
                        w_state_nxt = GAP;
                        w_us_d      = '0;
                        w_gap_d     = '0;
                    end else begin
                        w_start = 1'b1;
                    end
                end
            end
            GAP: if (w_tick) begin
                w_us_d = w_us_inc;
                if (w_us_inc == r_active.period) begin
                    w_us_d = '0;
                    if (r_gap + 8'd1 == r_active.boff) begin
                        w_start   = 1'b1;
                        w_restart = 1'b1;
                    end else begin
                        w_gap_d = r_gap + 8'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Period boundary: adopt any pending config and count this period in the burst.
        if (w_start) begin
            w_apply = r_pend;
            w_us_d  = '0;
            if (w_use.period == '0) begin
                w_state_nxt = IDLE;
                w_burst_d   = '0;
            end else begin
                w_state_nxt = (w_use.pw != '0) ? ON : OFF;
                w_burst_d   = w_restart ? 8'd1 : r_burst + 8'd1;
            end
        end

        if (!i_en && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_us_d      = '0;
            w_gap_d     = '0;
            w_burst_d   = '0;
            w_apply     = 1'b0;
        end
    end

    always_comb begin
        w_bucket_sum = {1'b0, r_bucket} + 17'(K_ON);
        w_bucket_d   = r_bucket;
        if (w_tick) begin
            if (r_pulse) begin
                w_bucket_d = w_bucket_sum[16] ? 16'hFFFF : w_bucket_sum[15:0];
            end else if (r_bucket != '0) begin
                w_bucket_d = r_bucket - 16'd1;
            end
        end
        w_fault_d = r_fault;
        if (w_bucket_d >= BKT_HI) begin
            w_fault_d = 1'b1;
        end else if (w_bucket_d < BKT_LO) begin
            w_fault_d = 1'b0;
        end
        // The limiter only masks the gate; FSM timing keeps running underneath.
        w_pulse_d = (w_state_nxt == ON) && !w_fault_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_active <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_us     <= '0;
            r_gap    <= '0;
            r_burst  <= '0;
            r_pulse  <= 1'b0;
            r_fault  <= 1'b0;
            r_bucket <= '0;
            r_pcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_us     <= w_us_d;
            r_gap    <= w_gap_d;
            r_burst  <= w_burst_d;
            r_pulse  <= w_pulse_d;
            r_fault  <= w_fault_d;
            r_bucket <= w_bucket_d;
            if (w_hs) begin
                r_shadow <= w_cfg_in;
                r_pend   <= 1'b1;
            end else if (w_apply) begin
                r_active <= w_apply_cfg;
                r_pend   <= 1'b0;
            end
            if (w_pulse_d && !r_pulse) begin
                r_pcnt <= r_pcnt + 16'd1;
            end
        end
    end

    assign cfg_bus.cfg_ready = !r_pend;
    assign o_pulse_out       = r_pulse;
    assign o_busy            = (r_state != IDLE);
    assign o_fault_duty      = r_fault;
    assign o_pulse_cnt       = r_pcnt;

endmodule

// File: tb/tb_int_burst_sched.sv
// tb/tb_int_burst_sched.sv - scoreboard bench for int_burst_sched pulse timing, bursts, config and duty limiter
module tb_int_burst_sched;

    localparam int M = 3;

    typedef struct {
        int gap;
        int width;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        o_pulse_out, o_busy, o_fault_duty;
    logic [15:0] o_pulse_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t mon_exp;
    bit   sb_active = 1'b0;
    logic mon_prev  = 1'b0;
    int   mon_last_rise = -1;
    int   mon_rise = 0;
    int   mon_gap  = -1;

    int_burst_sched_if bus ();

    int_burst_sched #(.CLK_MHZ(M), .BUCKET_MAX(4000), .K_ON(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .cfg_bus      (bus),
        .o_pulse_out  (o_pulse_out),
        .o_busy       (o_busy),
        .o_fault_duty (o_fault_duty),
        .o_pulse_cnt  (o_pulse_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sb_active && o_pulse_out && !mon_prev) begin
            mon_gap       = (mon_last_rise < 0) ? -1 : cyc - mon_last_rise;
            mon_last_rise = cyc;
            mon_rise      = cyc;
        end
        if (sb_active && !o_pulse_out && mon_prev) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: pulse of %0d clk at cycle %0d, required none", cyc - mon_rise, cyc);
            end else begin
                mon_exp = sb_q.pop_front();
                if (cyc - mon_rise !== mon_exp.width) begin
                    n_fail++;
                    $display("FAIL sb_width: got %0d clk, required %0d clk (cycle %0d)", cyc - mon_rise, mon_exp.width, cyc);
                end
                if (mon_exp.gap >= 0) begin
                    n_checks++;
                    if (mon_gap !== mon_exp.gap) begin
                        n_fail++;
                        $display("FAIL sb_gap: got %0d clk, required %0d clk (cycle %0d)", mon_gap, mon_exp.gap, cyc);
                    end
                end
            end
        end
        mon_prev = o_pulse_out;
    end

    task automatic push_exp(input int gap_us, input int width_us);
        exp_t e;
        e.gap   = (gap_us < 0) ? -1 : gap_us * M;
        e.width = width_us * M;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        sb_active     = 1'b0;
        en            = 1'b0;
        bus.cfg_valid = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst           = 1'b0;
        sb_q.delete();
        mon_last_rise = -1;
    endtask

    task automatic send_cfg(input int period, input int pw, input int bon, input int boff, output bit ok);
        int k;
        @(negedge clk);
        bus.cfg_period = 16'(period);
        bus.cfg_pw     = 8'(pw);
        bus.cfg_bon    = 8'(bon);
        bus.cfg_boff   = 8'(boff);
        bus.cfg_valid  = 1'b1;
        k = 0;
        while (bus.cfg_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        ok = (bus.cfg_ready === 1'b1);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int k;
        k = 0;
        while (bus.cfg_ready !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (bus.cfg_ready === 1'b1);
    endtask

    task automatic wait_rise(input int budget);
        int k;
        k = 0;
        while (o_pulse_out !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic start_run(input int period, input int pw, input int bon, input int boff, output bit ok);
        bit ok1, ok2;
        send_cfg(period, pw, bon, boff, ok1);
        wait_ready(M + 2, ok2);
        ok        = ok1 && ok2;
        sb_active = 1'b1;
        en        = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (o_pulse_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b, required 0", o_pulse_out); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
        n_checks++; if (o_fault_duty !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b, required 0", o_fault_duty); end
        n_checks++; if (o_pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", o_pulse_cnt); end
        n_checks++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.cfg_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        push_exp(-1, 10);
        push_exp(1000, 10);
        push_exp(1000, 10);
        start_run(1000, 10, 0, 0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_cfg_apply: got %b, required 1", ok); end
        wait_rise(2 * M + 4);
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", o_busy); end
        wait_drain(2100 * M);
        en = 1'b0;
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d pending, required 0", sb_q.size()); end
        n_checks++; if (o_pulse_cnt !== 16'd3) begin n_fail++; $display("FAIL basic_cnt: got %0d, required 3", o_pulse_cnt); end
    endtask

    task automatic test_clamp();
        bit ok;
        do_reset();
        push_exp(-1, 99);
        push_exp(100, 99);
        push_exp(100, 99);
        start_run(100, 200, 0, 0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL clamp_cfg_apply: got %b, required 1", ok); end
        wait_drain(400 * M);
        en = 1'b0;
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL clamp_drain: got %0d pending, required 0", sb_q.size()); end
        n_checks++; if (o_pulse_cnt !== 16'd3) begin n_fail++; $display("FAIL clamp_cnt: got %0d, required 3", o_pulse_cnt); end
    endtask

    task automatic test_burst();
        bit ok;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 3; i++) begin
                push_exp((b == 0 && i == 0) ? -1 : ((i == 0) ? 1500 : 500), 5);
            end
        end
        start_run(500, 5, 3, 2, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_cfg_apply: got %b, required 1", ok); end
        wait_drain(6500 * M);
        en = 1'b0;
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL burst_drain: got %0d pending, required 0", sb_q.size()); end
        n_checks++; if (o_pulse_cnt !== 16'd9) begin n_fail++; $display("FAIL burst_cnt: got %0d, required 9", o_pulse_cnt); end
    endtask

    task automatic test_cfg_update();
        bit ok;
        int c0;
        do_reset();
        push_exp(-1, 10);
        push_exp(200, 20);
        push_exp(200, 20);
        start_run(200, 10, 0, 0, ok);
        wait_rise(2 * M + 4);
        c0 = cyc;
        repeat (60) @(negedge clk);
        send_cfg(200, 20, 0, 0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL upd_handshake: got %b, required 1", ok); end
        n_checks++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL upd_ready_low: got %b, required 0", bus.cfg_ready); end
        while (cyc < c0 + 200 * M - 1) @(negedge clk);
        n_checks++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL upd_ready_held: got %b, required 0", bus.cfg_ready); end
        @(negedge clk);
        n_checks++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL upd_ready_boundary: got %b, required 1", bus.cfg_ready); end
        wait_drain(500 * M);
        en = 1'b0;
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL upd_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_duty();
        bit ok;
        int c0, k;
        do_reset();
        push_exp(-1, 50);
        for (int i = 0; i < 8; i++) push_exp(100, 50);
        push_exp(100, 45);
        push_exp(2100, 50);
        start_run(100, 50, 0, 0, ok);
        wait_rise(2 * M + 4);
        c0 = cyc;
        k  = 0;
        while (o_fault_duty !== 1'b1 && k < 1000 * M) begin @(negedge clk); k++; end
        n_checks++; if (cyc - c0 !== 945 * M) begin n_fail++; $display("FAIL duty_fault_rise: got %0d clk, required %0d clk", cyc - c0, 945 * M); end
        k = 0;
        while (o_fault_duty !== 1'b0 && k < 2100 * M) begin @(negedge clk); k++; end
        n_checks++; if (cyc - c0 !== 2951 * M) begin n_fail++; $display("FAIL duty_fault_clear: got %0d clk, required %0d clk", cyc - c0, 2951 * M); end
        wait_drain(200 * M);
        en = 1'b0;
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL duty_drain: got %0d pending, required 0", sb_q.size()); end
        n_checks++; if (o_pulse_cnt !== 16'd11) begin n_fail++; $display("FAIL duty_cnt: got %0d, required 11", o_pulse_cnt); end
    endtask

    task automatic test_en_and_rst();
        bit ok;
        do_reset();
        start_run(100, 50, 0, 0, ok);
        sb_active = 1'b0;
        wait_rise(2 * M + 4);
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_checks++; if (o_pulse_out !== 1'b0) begin n_fail++; $display("FAIL en_drop_pulse: got %b, required 0", o_pulse_out); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL en_drop_busy: got %b, required 0", o_busy); end
        en = 1'b1;
        wait_rise(2 * M + 4);
        n_checks++; if (o_pulse_cnt !== 16'd2) begin n_fail++; $display("FAIL en_restart_cnt: got %0d, required 2", o_pulse_cnt); end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (o_pulse_out !== 1'b0) begin n_fail++; $display("FAIL rst_pulse: got %b, required 0", o_pulse_out); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
        n_checks++; if (o_fault_duty !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b, required 0", o_fault_duty); end
        n_checks++; if (o_pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d, required 0", o_pulse_cnt); end
        n_checks++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", bus.cfg_ready); end
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_pw     = '0;
        bus.cfg_bon    = '0;
        bus.cfg_boff   = '0;
        test_reset();
        test_basic();
        test_clamp();
        test_burst();
        test_cfg_update();
        test_duty();
        test_en_and_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
